// File: rtl/seg7_scan_driver_if.sv
// Display bus between a host and the multiplexed 7-segment scan driver.
// Host side drives the data, enable and strobe signals; the driver drives the segments,
// the digit selects and the frame pulse.
interface seg7_scan_driver_if #(
  parameter int NDIG = 4
);
  logic [4*NDIG-1:0] value;
  logic [NDIG-1:0]   dp_in;
  logic [NDIG-1:0]   digit_en;
  logic [NDIG-1:0]   blink_mask;
  logic              load;
  logic [6:0]        seg;
  logic              dp_n;
  logic [NDIG-1:0]   an;
  logic              frame_done;

  modport master (
    output value, dp_in, digit_en, blink_mask, load,
    input  seg, dp_n, an, frame_done
  );

  modport slave (
    input  value, dp_in, digit_en, blink_mask, load,
    output seg, dp_n, an, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed hex 7-segment scan driver with double-buffered data and per-digit blink.
// Outputs are registered: they show the scan index and shadow of the previous cycle.
// No backpressure; load is a fire-and-forget strobe, and the latest one before a frame wins.
module seg7_scan_driver #(
  parameter int NDIG         = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input logic              clk,
  input logic              rst,
  seg7_scan_driver_if.slave bus
);

  localparam int PRE_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PRE_W-1:0]  presc;
  logic [IDX_W-1:0]  idx;
  logic [FC_W-1:0]   fcnt;
  logic              phase;
  logic [4*NDIG-1:0] pend_val;
  logic [NDIG-1:0]   pend_dp;
  logic [4*NDIG-1:0] shad_val;
  logic [NDIG-1:0]   shad_dp;

  logic              tick;
  logic              wrap;
  logic [3:0]        nib;
  logic              blank;
  logic [6:0]        seg_nxt;
  logic [NDIG-1:0]   an_nxt;
  logic              dp_n_nxt;

  assign tick = (presc == PRE_W'(CLK_DIV - 1));
  assign wrap = tick && (idx == IDX_W'(NDIG - 1));

  // Prescaler and scan index; the index only moves on the last prescaler count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= wrap ? '0 : idx + 1'b1;
    end
  end

  // Blink phase flips once every BLINK_FRAMES frame boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      if (fcnt == FC_W'(BLINK_FRAMES - 1)) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // Pending buffer takes every load; the shadow only changes at a frame boundary,
  // and a load landing on the boundary bypasses the pending stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_val <= '0;
      pend_dp  <= '0;
      shad_val <= '0;
      shad_dp  <= '0;
    end else begin
      if (bus.load) begin
        pend_val <= bus.value;
        pend_dp  <= bus.dp_in;
      end
      if (wrap) begin
        shad_val <= bus.load ? bus.value : pend_val;
        shad_dp  <= bus.load ? bus.dp_in : pend_dp;
      end
    end
  end

  // Decode the currently scanned digit and apply enable/blink blanking.
  always_comb begin
    nib      = shad_val[int'(idx)*4 +: 4];
    blank    = !bus.digit_en[idx] || (bus.blink_mask[idx] && phase);
    seg_nxt  = 7'h7F;
    an_nxt   = '1;
    dp_n_nxt = 1'b1;
    if (!blank) begin
      an_nxt   = ~(NDIG'(1) << idx);
      dp_n_nxt = ~shad_dp[idx];
      case (nib)
        4'h0: seg_nxt = 7'h40;
        4'h1: seg_nxt = 7'h79;
        4'h2: seg_nxt = 7'h24;
        4'h3: seg_nxt = 7'h30;
        4'h4: seg_nxt = 7'h19;
        4'h5: seg_nxt = 7'h12;
        4'h6: seg_nxt = 7'h02;
        4'h7: seg_nxt = 7'h78;
        4'h8: seg_nxt = 7'h00;
        4'h9: seg_nxt = 7'h10;
        4'hA: seg_nxt = 7'h08;
        4'hB: seg_nxt = 7'h03;
        4'hC: seg_nxt = 7'h46;
        4'hD: seg_nxt = 7'h21;
        4'hE: seg_nxt = 7'h06;
        default: seg_nxt = 7'h0E;
      endcase
    end
  end

  // Output registers, including the frame pulse for the cycle after a wrap edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.seg        <= 7'h7F;
      bus.dp_n       <= 1'b1;
      bus.an         <= '1;
      bus.frame_done <= 1'b0;
    end else begin
      bus.seg        <= seg_nxt;
      bus.dp_n       <= dp_n_nxt;
      bus.an         <= an_nxt;
      bus.frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a 4-digit and a 1-digit instance share clock, reset and loads.
// Expected outputs come from arithmetic on the edge count since reset and a log of loads.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] val_v = '0;
  logic [3:0]  dp_v = '0;
  logic [3:0]  en_v = '0;
  logic [3:0]  mask_v = '0;
  logic        load_v = 1'b0;

  int compared = 0;
  int mismatched = 0;
  int edge_n = 0;
  int          ld_edge[$];
  logic [15:0] ld_val[$];
  logic [3:0]  ld_dp[$];

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NDIG(4)) bus0 ();
  seg7_scan_driver_if #(.NDIG(1)) bus1 ();

  assign bus0.value      = val_v;
  assign bus0.dp_in      = dp_v;
  assign bus0.digit_en   = en_v;
  assign bus0.blink_mask = mask_v;
  assign bus0.load       = load_v;
  assign bus1.value      = val_v[3:0];
  assign bus1.dp_in      = dp_v[0];
  assign bus1.digit_en   = en_v[0];
  assign bus1.blink_mask = mask_v[0];
  assign bus1.load       = load_v;

  seg7_scan_driver #(.NDIG(4), .CLK_DIV(4), .BLINK_FRAMES(2)) u0 (
    .clk(clk), .rst(rst), .bus(bus0));
  seg7_scan_driver #(.NDIG(1), .CLK_DIV(2), .BLINK_FRAMES(1)) u1 (
    .clk(clk), .rst(rst), .bus(bus1));

  function automatic logic [6:0] hexseg(input logic [3:0] d);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[d];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s differs", tag);
    end
  endtask

  // Model: after edge n the outputs show the state reached after n-1 edges.
  task automatic check_inst(input string name, input int nd, input int cd, input int bf,
                            input logic [6:0] seg, input logic dp_n, input logic [7:0] an,
                            input logic fd);
    int m = edge_n - 1;
    int p = nd * cd;
    int idx = (m / cd) % nd;
    int f = m / p;
    int b = f * p;
    bit ph = ((f / bf) % 2) == 1;
    logic [15:0] sv = '0;
    logic [3:0]  sd = '0;
    logic [7:0]  all = 8'hFF >> (8 - nd);
    bit blank;
    for (int k = 0; k < ld_edge.size(); k++)
      if (ld_edge[k] <= b) begin
        sv = ld_val[k];
        sd = ld_dp[k];
      end
    blank = !en_v[idx] || (mask_v[idx] && ph);
    chk($sformatf("%s.an@%0d", name, edge_n), an,
        blank ? all : (all & ~(8'h01 << idx)));
    chk($sformatf("%s.seg@%0d", name, edge_n), {1'b0, seg},
        blank ? 8'h7F : {1'b0, hexseg(sv[idx*4 +: 4])});
    chk($sformatf("%s.dp_n@%0d", name, edge_n), {7'b0, dp_n},
        blank ? 8'h01 : {7'b0, ~sd[idx]});
    chk($sformatf("%s.frame_done@%0d", name, edge_n), {7'b0, fd},
        {7'b0, (edge_n % p) == 0});
  endtask

  task automatic check_reset(input string when);
    chk({when, ".u0.an"},  {4'b0, bus0.an}, 8'h0F);
    chk({when, ".u0.seg"}, {1'b0, bus0.seg}, 8'h7F);
    chk({when, ".u0.dp_n"}, {7'b0, bus0.dp_n}, 8'h01);
    chk({when, ".u0.fd"},  {7'b0, bus0.frame_done}, 8'h00);
    chk({when, ".u1.an"},  {7'b0, bus1.an}, 8'h01);
    chk({when, ".u1.seg"}, {1'b0, bus1.seg}, 8'h7F);
    chk({when, ".u1.fd"},  {7'b0, bus1.frame_done}, 8'h00);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
    check_inst("u0", 4, 4, 2, bus0.seg, bus0.dp_n, {4'b0, bus0.an}, bus0.frame_done);
    check_inst("u1", 1, 2, 1, bus1.seg, bus1.dp_n, {7'b0, bus1.an}, bus1.frame_done);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    val_v = v;
    dp_v = d;
    load_v = 1'b1;
    ld_edge.push_back(edge_n + 1);
    ld_val.push_back(v);
    ld_dp.push_back(d);
    step();
    load_v = 1'b0;
  endtask

  task automatic restart();
    rst = 1'b0;
    edge_n = 0;
    ld_edge.delete();
    ld_val.delete();
    ld_dp.delete();
  endtask

  initial begin
    // Reset held across several edges.
    repeat (3) @(posedge clk);
    #1;
    check_reset("hold");
    en_v = 4'hF;
    restart();

    // Digits show 0 from reset, then a loaded value after the next frame boundary.
    run(6);
    do_load(16'h3A7F, 4'b0000);
    run(40);

    // Load mid-frame while digit 2 is being scanned.
    while (((edge_n / 4) % 4) != 2) step();
    do_load(16'h1234, 4'b0100);
    run(36);

    // Load on the exact frame-boundary edge.
    while (((edge_n + 1) % 16) != 0) step();
    do_load(16'hBCDE, 4'b1001);
    run(20);

    // Blink on digit 0.
    mask_v = 4'b0001;
    run(90);

    // Sparse enables with decimal points.
    mask_v = 4'b0000;
    en_v = 4'b1010;
    do_load(16'h5968, 4'b1111);
    run(40);

    // Randomized loads and enable/blink changes.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        do_load(16'($urandom), 4'($urandom));
      end else begin
        if ($urandom_range(0, 31) == 0) begin
          en_v = 4'($urandom);
          mask_v = 4'($urandom);
        end
        step();
      end
    end

    // Asynchronous reset mid-cycle while digit 3 is scanned, with a load still pending.
    en_v = 4'hF;
    mask_v = 4'b0000;
    while (((edge_n / 4) % 4) != 3) step();
    do_load(16'hFFFF, 4'hF);
    #3;
    rst = 1'b1;
    #1;
    check_reset("async");
    @(posedge clk);
    #1;
    check_reset("held");
    restart();
    mask_v = 4'b0101;
    run(80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
